// File: rtl/wca_rx_packer_pkg.sv
// Shared definitions for the receive-sample packer.
//   state_e        : packer sequencer states (IDLE, then one state per pushed word)
//   MODE_*         : values of the mode input
//   WORDS_*        : FIFO words produced per accepted unit in each mode
//   sext12()       : sign-extends a 12-bit component to a 16-bit word
package wca_rx_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2,
    ST_W2   = 2'd3
  } state_e;

  localparam logic MODE_UNPACKED = 1'b0;
  localparam logic MODE_PACKED   = 1'b1;

  localparam int WORDS_UNPACKED = 2;
  localparam int WORDS_PACKED   = 3;

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/wca_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : synchronous empty (same effect as reset on pointers/level)
//   wr_en/wr_data: push; ignored when full
//   rd_en        : pop of the head word; ignored when empty
//   rd_data      : head word, forced to zero while empty
//   empty, level : occupancy status (level counts words, 0..DEPTH)
module wca_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;
  logic             do_wr, do_rd;

  assign do_wr = wr_en && (level_q != (AW+1)'(DEPTH)) && !clear;
  assign do_rd = rd_en && (level_q != '0) && !clear;

  // NOTE: every variable assigned in always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; it is only ever read
  // through a valid pointer, and the empty case is masked on rd_data.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/wca_rx_packer.sv
// Packs 24-bit I/Q receive samples into a 16-bit word stream.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   rx_iq, rx_strobe    : input sample (I = [11:0], Q = [23:12]) and its valid pulse
//   enable, mode        : capture enable; 0 = two sign-extended words per sample,
//                         1 = three words per sample pair (A then B)
//   flush               : clears sequencer, pairing state and FIFO
//   ovf_clear           : clears overflow flag and drop counter
//   out_data/out_valid/out_ready : FWFT word stream with valid/ready handshake
//   level               : FIFO occupancy in words
//   overflow, ovf_count : sticky drop flag and saturating drop-event count
module wca_rx_packer
  import wca_rx_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [23:0]                   rx_iq,
  input  logic                          rx_strobe,
  input  logic                          enable,
  input  logic                          mode,
  input  logic                          flush,
  input  logic                          ovf_clear,
  output logic [15:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [7:0]                    ovf_count
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  // An accept needs room for its whole word group; above these levels it drops.
  localparam logic [LW-1:0] LIM_UNPACKED = LW'(FIFO_DEPTH - WORDS_UNPACKED);
  localparam logic [LW-1:0] LIM_PACKED   = LW'(FIFO_DEPTH - WORDS_PACKED);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [23:0] hold_q, hold_d;
  // Word group source captured at accept: {B, A} in packed mode, {0, sample}
  // in unpacked mode. Keeping it separate from hold lets a running sequence
  // finish even if pairing state is discarded meanwhile.
  logic [47:0] pair_q, pair_d;
  logic        seq_mode_q, seq_mode_d;
  logic        mode_prev_q, mode_prev_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  ovf_count_q, ovf_count_d;

  logic        push;
  logic [15:0] push_data;
  logic        drop;
  logic        strobe_en;
  logic        phase_live;
  logic        fifo_empty;
  logic [LW-1:0] fifo_level;

  assign strobe_en  = rx_strobe && enable && !flush;
  // A held A survives only while enable stays high and mode is unchanged.
  assign phase_live = phase_q && enable && (mode == mode_prev_q);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_live;
    hold_d      = phase_live ? hold_q : 24'h0;
    pair_d      = pair_q;
    seq_mode_d  = seq_mode_q;
    mode_prev_d = mode;
    overflow_d  = overflow_q;
    ovf_count_d = ovf_count_q;
    push        = 1'b0;
    push_data   = 16'h0;
    drop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (strobe_en) begin
          if (mode == MODE_UNPACKED) begin
            if (fifo_level > LIM_UNPACKED) begin
              drop = 1'b1;
            end else begin
              pair_d     = {24'h0, rx_iq};
              seq_mode_d = MODE_UNPACKED;
              state_d    = ST_W0;
            end
          end else if (!phase_live) begin
            hold_d  = rx_iq;
            phase_d = 1'b1;
          end else begin
            // Sample B: the pair either goes out whole or not at all.
            phase_d = 1'b0;
            hold_d  = 24'h0;
            if (fifo_level > LIM_PACKED) begin
              drop = 1'b1;
            end else begin
              pair_d     = {rx_iq, hold_q};
              seq_mode_d = MODE_PACKED;
              state_d    = ST_W0;
            end
          end
        end
      end
      ST_W0: begin
        push      = 1'b1;
        push_data = (seq_mode_q == MODE_UNPACKED) ? sext12(pair_q[11:0]) : pair_q[15:0];
        state_d   = ST_W1;
      end
      ST_W1: begin
        push      = 1'b1;
        push_data = (seq_mode_q == MODE_UNPACKED) ? sext12(pair_q[23:12]) : pair_q[31:16];
        state_d   = (seq_mode_q == MODE_UNPACKED) ? ST_IDLE : ST_W2;
      end
      ST_W2: begin
        push      = 1'b1;
        push_data = pair_q[47:32];
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe arriving while a word group is still being written is lost.
    if (state_q != ST_IDLE && strobe_en) drop = 1'b1;

    if (flush) begin
      state_d = ST_IDLE;
      phase_d = 1'b0;
      hold_d  = 24'h0;
      push    = 1'b0;
    end

    // A drop in the same cycle as ovf_clear wins and counts as the first event.
    if (drop) begin
      overflow_d  = 1'b1;
      ovf_count_d = ovf_clear ? 8'd1 :
                    (ovf_count_q == 8'hFF) ? 8'hFF : ovf_count_q + 8'd1;
    end else if (ovf_clear) begin
      overflow_d  = 1'b0;
      ovf_count_d = 8'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      hold_q      <= 24'h0;
      pair_q      <= 48'h0;
      seq_mode_q  <= MODE_UNPACKED;
      mode_prev_q <= MODE_UNPACKED;
      overflow_q  <= 1'b0;
      ovf_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      pair_q      <= pair_d;
      seq_mode_q  <= seq_mode_d;
      mode_prev_q <= mode_prev_d;
      overflow_q  <= overflow_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  wca_sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (out_ready && !fifo_empty),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign level     = fifo_level;
  assign overflow  = overflow_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_wca_rx_packer.sv
// Self-checking bench for wca_rx_packer: directed scenarios with fixed
// expected words, then randomized traffic compared every cycle against a
// queue-based reference model of the packer.
module tb_wca_rx_packer;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] rx_iq;
  logic        rx_strobe, enable, mode, flush, ovf_clear, out_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  ovf_count;

  wca_rx_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_iq     (rx_iq),
    .rx_strobe (rx_strobe),
    .enable    (enable),
    .mode      (mode),
    .flush     (flush),
    .ovf_clear (ovf_clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .ovf_count (ovf_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: fq = words in the FIFO, pq = words still to be written
  // by the current word group (one per cycle; non-empty means busy).
  int m_fq[$];
  int m_pq[$];
  bit m_phase;
  int m_hold;
  bit m_prev_mode;
  bit m_ovf;
  int m_cnt;

  logic [15:0] log_q[$];

  function automatic int sext(input int v);
    return (v >= 2048) ? v + 61440 : v;
  endfunction

  task automatic model_edge();
    bit drop = 0;
    int lvl, iq, a, b;
    bit busy, do_pop;
    if (reset) begin
      m_fq.delete(); m_pq.delete();
      m_phase = 0; m_hold = 0; m_prev_mode = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    if (flush) begin
      m_fq.delete(); m_pq.delete(); m_phase = 0;
    end else begin
      lvl    = m_fq.size();
      busy   = (m_pq.size() > 0);
      do_pop = out_ready && (lvl > 0);
      iq     = int'(rx_iq);
      if (!enable || (mode != m_prev_mode)) m_phase = 0;
      if (rx_strobe && enable) begin
        if (busy) drop = 1;
        else if (mode == 1'b0) begin
          if (DEPTH - lvl < 2) drop = 1;
          else begin
            m_pq.push_back(sext(iq % 4096));
            m_pq.push_back(sext(iq / 4096));
          end
        end else if (!m_phase) begin
          m_hold = iq; m_phase = 1;
        end else begin
          m_phase = 0;
          if (DEPTH - lvl < 3) drop = 1;
          else begin
            a = m_hold; b = iq;
            m_pq.push_back(a % 65536);
            m_pq.push_back((b % 256) * 256 + a / 65536);
            m_pq.push_back(b / 256);
          end
        end
      end
      if (do_pop) void'(m_fq.pop_front());
      if (busy) m_fq.push_back(m_pq.pop_front());
    end
    m_prev_mode = mode;
    if (drop) begin
      m_ovf = 1;
      m_cnt = ovf_clear ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (ovf_clear) begin
      m_ovf = 0; m_cnt = 0;
    end
  endtask

  task automatic compare();
    check("out_valid", out_valid, (m_fq.size() > 0));
    check("level", level, m_fq.size());
    check("out_data", out_data, (m_fq.size() > 0) ? m_fq[0] : 0);
    check("overflow", overflow, m_ovf);
    check("ovf_count", ovf_count, m_cnt);
  endtask

  task automatic step();
    #1;
    if (out_valid && out_ready) log_q.push_back(out_data);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic send(input logic [23:0] iq);
    rx_iq = iq; rx_strobe = 1'b1;
    step();
    rx_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_flush();
    flush = 1'b1; ovf_clear = 1'b1;
    step();
    flush = 1'b0; ovf_clear = 1'b0;
  endtask

  int ready_pct;

  initial begin
    reset = 1'b1; rx_iq = '0; rx_strobe = 1'b0; enable = 1'b1; mode = 1'b0;
    flush = 1'b0; ovf_clear = 1'b0; out_ready = 1'b0;
    idle(2);
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", ovf_count, 0);
    reset = 1'b0;
    idle(1);

    // Unpacked sample and its latency.
    out_ready = 1'b1; log_q.delete();
    send(24'hF00100);
    check("lat_1cyc", out_valid, 0);
    step();
    check("lat_2cyc", out_valid, 1);
    idle(4);
    check("m0_nwords", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("m0_w0", log_q[0], 16'h0100);
      check("m0_w1", log_q[1], 16'hFF00);
    end

    // Packed pair.
    mode = 1'b1; idle(1); log_q.delete();
    send(24'hABC123);
    send(24'h456DEF);
    idle(6);
    check("m1_nwords", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("m1_w0", log_q[0], 16'hC123);
      check("m1_w1", log_q[1], 16'hEFAB);
      check("m1_w2", log_q[2], 16'h456D);
    end

    // Fill to full with unpacked samples; the ninth is dropped.
    out_ready = 1'b0; mode = 1'b0;
    do_flush();
    for (int i = 0; i < 9; i++) begin
      send(24'($urandom));
      idle(3);
    end
    check("full_level", level, 16);
    check("full_ovf", overflow, 1);
    check("full_cnt", ovf_count, 1);

    // Strobe one cycle after an accept is dropped; first sample intact.
    do_flush();
    out_ready = 1'b1; log_q.delete();
    send(24'h7FF800);
    send(24'h123456);
    idle(5);
    check("busy_cnt", ovf_count, 1);
    check("busy_nwords", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("busy_w0", log_q[0], 16'hF800);
      check("busy_w1", log_q[1], 16'h07FF);
    end

    // Enable toggle discards a held A.
    mode = 1'b1; idle(1); log_q.delete();
    send(24'h111111);
    enable = 1'b0; step(); enable = 1'b1;
    send(24'h89ABCD);
    send(24'h13579B);
    idle(6);
    check("pair_nwords", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("pair_w0", log_q[0], 16'hABCD);
      check("pair_w1", log_q[1], 16'h9B89);
      check("pair_w2", log_q[2], 16'h1357);
    end

    // Flush in the middle of W1 with five words stored.
    out_ready = 1'b0; mode = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    send(24'h000001); idle(2);
    send(24'h000002); idle(2);
    send(24'h000003);
    step();
    check("pre_flush_level", level, 5);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_valid", out_valid, 0);
    check("flush_cnt", ovf_count, 1);
    send(24'h000004); idle(2);
    check("post_flush_level", level, 2);

    // Drop-counter saturation.
    ovf_clear = 1'b1; step(); ovf_clear = 1'b0;
    rx_strobe = 1'b1;
    repeat (340) begin
      rx_iq = 24'($urandom);
      step();
    end
    rx_strobe = 1'b0;
    check("sat_cnt", ovf_count, 255);
    check("sat_ovf", overflow, 1);

    // Randomized traffic against the model.
    do_flush();
    ready_pct = 75;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) ready_pct = $urandom_range(10, 100);
      rx_strobe = ($urandom_range(0, 2) == 0);
      rx_iq     = 24'($urandom);
      enable    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      out_ready = ($urandom_range(1, 100) <= ready_pct);
      flush     = ($urandom_range(0, 96) == 0);
      ovf_clear = ($urandom_range(0, 149) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; ovf_clear = 1'b0; rx_strobe = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wca_rx_packer.md
WCA_RX_PACKER -- requirements
Module: wca_rx_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output FIFO depth in 16-bit words, power of two, minimum 4.
REQ-002 Port clock  input  1  DSP sampling clock; the block has one clock and every register is clocked on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port rx_iq  input  24  receive sample: I = rx_iq[11:0], Q = rx_iq[23:12], two's complement.
REQ-005 Port rx_strobe  input  1  one-clock pulse marking a valid rx_iq.
REQ-006 Port enable  input  1  capture enable.
REQ-007 Port mode  input  1  0 = unpacked (2 words/sample), 1 = packed (3 words per sample pair).
REQ-008 Port flush  input  1  synchronous clear of packer and FIFO.
REQ-009 Port ovf_clear  input  1  clears the overflow flag and counter.
REQ-010 Port out_data  output  16  head word of the FIFO.
REQ-011 Port out_valid  output  1  FIFO not empty.
REQ-012 Port out_ready  input  1  consumer accepts; a word transfers when out_valid and out_ready are both 1.
REQ-013 Port level  output  log2(FIFO_DEPTH)+1  FIFO occupancy in words.
REQ-014 Port overflow  output  1  sticky flag, set on any dropped sample.
REQ-015 Port ovf_count  output  8  count of drop events, saturating at 255.

Function
REQ-016 A sample is accepted when rx_strobe=1, enable=1, flush=0 and the state is IDLE; rx_iq is registered in the accept cycle.
REQ-017 State machine states are IDLE, W0, W1, W2; W0..W2 each push exactly one word into the FIFO; no other state pushes.
REQ-018 Mode 0 accept: the block SHALL go IDLE->W0->W1->IDLE, pushing W0={{4{I[11]}},I} and then W1={{4{Q[11]}},Q}.
REQ-019 Mode 1: the first sample of a pair (A) is stored in a 24-bit hold register, the phase flag is set, and the block stays in IDLE with no push.
REQ-020 Mode 1: the second sample (B) drives IDLE->W0->W1->W2->IDLE, pushing A[15:0], then {B[7:0],A[23:16]}, then B[23:8], and then clears the phase flag.
REQ-021 An accepted sample SHALL be dropped if free space (FIFO_DEPTH-level, using the registered level with no credit for a same-cycle read) is below 2 in mode 0, or below 3 for sample B in mode 1; sample A in mode 1 SHALL never be dropped for lack of space.
REQ-022 A mode 1 drop of sample B SHALL also discard the held A and clear the phase flag, so that output word alignment is preserved.
REQ-023 rx_strobe=1 with enable=1 while the state is not IDLE SHALL be treated as a drop.
REQ-024 Each drop event SHALL set overflow and increment ovf_count by 1, saturating at 255.
REQ-025 If ovf_clear and a drop event occur in the same cycle, the result SHALL be overflow=1 and ovf_count=1.
REQ-026 A change of mode, or enable=0, SHALL clear the phase flag and discard any held A; a W-sequence already in progress SHALL complete with the mode it was accepted under.
REQ-027 mode SHALL be sampled only in IDLE at accept.
REQ-028 flush SHALL force IDLE, clear the phase flag and empty the FIFO (level=0, out_valid=0) on the next edge; a same-cycle strobe is discarded and not counted; overflow and ovf_count are unchanged.
REQ-029 FIFO is first-word-fall-through: a word pushed at edge N SHALL appear on out_valid/out_data after edge N, so accept-to-out_valid latency is 2 cycles in mode 0 and 2 cycles after the B accept in mode 1.
REQ-030 A simultaneous push and pop SHALL leave level unchanged; a pop when empty, or a push when full, SHALL never occur.
REQ-031 The FIFO SHALL continue to drain while enable=0.

Reset
REQ-032 On reset: state=IDLE, phase=0, hold=0, level=0, out_valid=0, out_data=0, overflow=0, ovf_count=0.
REQ-033 Reset SHALL take priority over flush, ovf_clear and rx_strobe.

Structure
REQ-034 Package wca_rx_packer_pkg SHALL hold the state enumeration, the MODE_UNPACKED=0 and MODE_PACKED=1 constants, and the per-mode word-count constants (2 and 3).
REQ-035 The FIFO SHALL be a separate sub-module wca_sync_fifo (parameters WIDTH=16 and DEPTH; ports clock, reset, clear, wr_en, wr_data, rd_en, rd_data, empty, level).

Verification
REQ-036 Mode 0, rx_iq=24'hF00100, one strobe, out_ready=1 -> words 16'h0100 then 16'hFF00, with out_valid first high 2 cycles after accept.
REQ-037 Mode 1, samples 24'hABC123 then 24'h456DEF -> words 16'hC123, 16'hEFAB, 16'h456D.
REQ-038 Mode 0, out_ready=0, strobes every 4 cycles, FIFO_DEPTH=16 -> 8 samples stored (level=16), 9th sample dropped, overflow=1, ovf_count=1.
REQ-039 Strobe 1 cycle after a mode 0 accept -> sample dropped, ovf_count increments, the first sample's two words are intact.
REQ-040 Mode 1, A accepted, enable toggled 1->0->1, then samples C and D -> output is the C/D triple only, no A words.
REQ-041 flush asserted mid-W1 with level=5 -> next cycle level=0, out_valid=0, state=IDLE, ovf_count unchanged; 300 drop events -> ovf_count=255.
